// File: rtl/fp_operand_classifier.sv
// IEEE-754 operand classifier with a one-deep valid/ready output register,
// sticky status flags and a saturating SNaN counter. Optional macro: FPCLASS_DAZ_EN.
module fp_operand_classifier #(
    parameter int EXP_W   = 8,
    parameter int FRAC_W  = 23,
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_OPS*(1+EXP_W+FRAC_W)-1:0] in_ops,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_OPS*(1+EXP_W+FRAC_W)-1:0] out_ops,
    output logic [NUM_OPS*6-1:0]                out_class,
    output logic                                out_any_nan,
    input  logic                                flags_clr,
    output logic                                flag_invalid,
    output logic                                flag_nan,
    output logic                                flag_inf,
    output logic                                flag_sub,
    output logic [CNT_W-1:0]                    snan_cnt
);
    localparam int W = 1 + EXP_W + FRAC_W;

    // Class bit positions inside each 6-bit group.
    localparam int C_ZERO = 0;
    localparam int C_SUB  = 1;
    localparam int C_NORM = 2;
    localparam int C_INF  = 3;
    localparam int C_QNAN = 4;
    localparam int C_SNAN = 5;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready is combinational so a full register can drain and reload in one cycle.
    logic accept;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    logic [NUM_OPS*W-1:0] ops_nxt;
    logic [NUM_OPS*6-1:0] cls_nxt;
    logic                 nan_nxt;
    logic                 ev_invalid, ev_nan, ev_inf, ev_sub;
    logic [CNT_W:0]       snan_add;
    logic [EXP_W-1:0]     exp_f;
    logic [FRAC_W-1:0]    frac_f;
    logic [5:0]           cls_op;

    always_comb begin
        ops_nxt    = in_ops;
        cls_nxt    = '0;
        nan_nxt    = 1'b0;
        ev_invalid = 1'b0;
        ev_nan     = 1'b0;
        ev_inf     = 1'b0;
        ev_sub     = 1'b0;
        snan_add   = '0;
        exp_f      = '0;
        frac_f     = '0;
        cls_op     = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            exp_f  = in_ops[i*W+FRAC_W +: EXP_W];
            frac_f = in_ops[i*W +: FRAC_W];
            cls_op = '0;
            if (exp_f == '0) begin
                if (frac_f == '0) begin
                    cls_op[C_ZERO] = 1'b1;
                end else begin
                    ev_sub = 1'b1;
`ifdef FPCLASS_DAZ_EN
                    // Flushed subnormal keeps sign and exponent, loses fraction.
                    cls_op[C_ZERO] = 1'b1;
                    ops_nxt[i*W +: FRAC_W] = '0;
`else
                    cls_op[C_SUB] = 1'b1;
`endif
                end
            end else if (exp_f == '1) begin
                if (frac_f == '0) begin
                    cls_op[C_INF] = 1'b1;
                    ev_inf = 1'b1;
                end else if (frac_f[FRAC_W-1]) begin
                    cls_op[C_QNAN] = 1'b1;
                    ev_nan = 1'b1;
                end else begin
                    cls_op[C_SNAN] = 1'b1;
                    ev_nan     = 1'b1;
                    ev_invalid = 1'b1;
                    snan_add   = snan_add + (CNT_W+1)'(1);
                end
            end else begin
                cls_op[C_NORM] = 1'b1;
            end
            cls_nxt[i*6 +: 6] = cls_op;
        end
        nan_nxt = ev_nan;
    end

    // Clear happens first so a simultaneous accept still records its events.
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_base = flags_clr ? '0 : snan_cnt;
        cnt_sum  = {1'b0, cnt_base} + (accept ? snan_add : '0);
        cnt_nxt  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_ops      <= '0;
            out_class    <= '0;
            out_any_nan  <= 1'b0;
            flag_invalid <= 1'b0;
            flag_nan     <= 1'b0;
            flag_inf     <= 1'b0;
            flag_sub     <= 1'b0;
            snan_cnt     <= '0;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_ops     <= ops_nxt;
                out_class   <= cls_nxt;
                out_any_nan <= nan_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            flag_invalid <= (flag_invalid && !flags_clr) || (accept && ev_invalid);
            flag_nan     <= (flag_nan && !flags_clr) || (accept && ev_nan);
            flag_inf     <= (flag_inf && !flags_clr) || (accept && ev_inf);
            flag_sub     <= (flag_sub && !flags_clr) || (accept && ev_sub);
            snan_cnt     <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fp_operand_classifier.sv
// Bench for fp_operand_classifier (EXP_W=8, FRAC_W=23, NUM_OPS=2, CNT_W=8);
// honours FPCLASS_DAZ_EN when defined.
module tb_fp_operand_classifier;
    localparam int W  = 32;
    localparam int N  = 2;
    localparam int EW = N*W + N*6 + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*W-1:0] in_ops = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N*W-1:0] out_ops;
    logic [N*6-1:0] out_class;
    logic          out_any_nan;
    logic          flags_clr = 1'b0;
    logic          flag_invalid, flag_nan, flag_inf, flag_sub;
    logic [7:0]    snan_cnt;

    fp_operand_classifier dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .out_valid(out_valid), .out_ready(out_ready),
        .out_ops(out_ops), .out_class(out_class), .out_any_nan(out_any_nan),
        .flags_clr(flags_clr), .flag_invalid(flag_invalid), .flag_nan(flag_nan),
        .flag_inf(flag_inf), .flag_sub(flag_sub), .snan_cnt(snan_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [EW-1:0] exp_q[$];
    logic          m_valid = 1'b0;
    logic          m_inv = 1'b0, m_nan = 1'b0, m_inf = 1'b0, m_sub = 1'b0;
    int            m_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;

`ifdef FPCLASS_DAZ_EN
    localparam bit DAZ = 1'b1;
`else
    localparam bit DAZ = 1'b0;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raw class index: 0 zero, 1 sub, 2 norm, 3 inf, 4 qnan, 5 snan (no DAZ).
    function automatic int raw_class(input logic [31:0] op);
        int e, f;
        e = int'(op[30:23]);
        f = int'(op[22:0]);
        if (e == 255) begin
            if (f == 0) return 3;
            return (f >= (1 << 22)) ? 4 : 5;
        end
        if (e == 0) return (f == 0) ? 0 : 1;
        return 2;
    endfunction

    function automatic logic [EW-1:0] model_out(input logic [N*W-1:0] ops);
        logic [N*W-1:0] o;
        logic [N*6-1:0] c;
        logic           any;
        logic [31:0]    op;
        int             k;
        o = ops; c = '0; any = 1'b0;
        for (int i = 0; i < N; i++) begin
            op = ops[i*W +: W];
            k = raw_class(op);
            if (DAZ && k == 1) begin
                k = 0;
                o[i*W +: W] = {op[31:23], 23'd0};
            end
            c[i*6 +: 6] = 6'(1 << k);
            if (k >= 4) any = 1'b1;
        end
        return {o, c, any};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 3))
            0: e = 8'd0;
            1: e = 8'd255;
            default: e = 8'($urandom_range(1, 254));
        endcase
        case ($urandom_range(0, 2))
            0: f = 23'd0;
            1: f = 23'($urandom_range(1, 255));
            default: f = 23'($urandom);
        endcase
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    // One clock of stimulus; starts and ends 1 time unit after a rising edge.
    task automatic cycle(input logic v, input logic [N*W-1:0] ops, input logic ordy, input logic clr);
        logic exp_rdy, acc;
        int   k, ns;
        in_valid = v; in_ops = ops; out_ready = ordy; flags_clr = clr;
        #1;
        exp_rdy = !m_valid || ordy;
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        acc = v && exp_rdy;
        if (acc) exp_q.push_back(model_out(ops));
        @(posedge clk);
        if (clr) begin
            m_inv = 0; m_nan = 0; m_inf = 0; m_sub = 0; m_cnt = 0;
        end
        if (acc) begin
            ns = 0;
            for (int i = 0; i < N; i++) begin
                k = raw_class(ops[i*W +: W]);
                if (k == 1) m_sub = 1;
                if (k == 3) m_inf = 1;
                if (k >= 4) m_nan = 1;
                if (k == 5) begin m_inv = 1; ns++; end
            end
            m_cnt = (m_cnt + ns > 255) ? 255 : m_cnt + ns;
        end
        m_valid = acc ? 1'b1 : (ordy ? 1'b0 : m_valid);
        #1;
    endtask

    // Monitor: compares the held output against the queue head; pops on transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 128'(out_valid), 128'(m_valid));
            check("flags", 128'({flag_invalid, flag_nan, flag_inf, flag_sub}),
                  128'({m_inv, m_nan, m_inf, m_sub}));
            check("snan_cnt", 128'(snan_cnt), 128'(m_cnt));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 128'(out_valid), 128'(0));
                end else begin
                    check("out_data", 128'({out_ops, out_class, out_any_nan}), 128'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_outs", 128'({out_valid, out_ops, out_class, out_any_nan}), 128'(0));
        check("rst_flags", 128'({flag_invalid, flag_nan, flag_inf, flag_sub, snan_cnt}), 128'(0));
        rst_n = 1'b1;

        // Normal and zero.
        cycle(1, {32'h80000000, 32'h3F800000}, 1, 0);
        check("t1_class", 128'(out_class), 128'(12'h044));
        check("t1_nan", 128'(out_any_nan), 128'(0));
        // Inf and quiet NaN.
        cycle(1, {32'h7FC00000, 32'h7F800000}, 1, 0);
        check("t2_class", 128'(out_class), 128'(12'h408));
        // Saturating SNaN counter: 400 SNaNs total.
        for (int i = 0; i < 200; i++) cycle(1, {32'hFF800001, 32'h7F800001}, 1, 0);
        check("t3_flags", 128'({flag_invalid, flag_nan, flag_inf}), 128'(3'b111));
        check("t3_cnt_sat", 128'(snan_cnt), 128'(255));
        // Backpressure: first accepted, the rest stall until out_ready rises.
        cycle(0, '0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, {32'h3F800000, 32'(32'h40000000 + i)}, 0, 0);
        check("t4_stall_ops", 128'(out_ops), 128'({32'h3F800000, 32'h40000000}));
        cycle(1, {32'h3F800000, 32'h40000004}, 1, 0);
        check("t4_reload_ops", 128'(out_ops), 128'({32'h3F800000, 32'h40000004}));
        // Clear together with an SNaN accept.
        cycle(1, {32'h3F800000, 32'h7F800001}, 1, 1);
        check("t5_inv", 128'(flag_invalid), 128'(1));
        check("t5_cnt", 128'(snan_cnt), 128'(1));
        // Clear alone.
        cycle(0, '0, 1, 1);
        check("clr_flags", 128'({flag_invalid, flag_nan, flag_inf, flag_sub, snan_cnt}), 128'(0));
        // Subnormal.
        cycle(1, {32'h3F800000, 32'h00000001}, 1, 0);
        check("t6_sub_flag", 128'(flag_sub), 128'(1));
        check("t6_ops", 128'(out_ops[31:0]), DAZ ? 128'(0) : 128'(1));
        check("t6_class", 128'(out_class[5:0]), DAZ ? 128'(6'h01) : 128'(6'h02));

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 3) != 0), {rand_op(), rand_op()},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

        // Reset while a transaction is held.
        cycle(0, '0, 1, 0);
        cycle(1, {32'h7F800001, 32'h7F800000}, 0, 0);
        cycle(0, '0, 0, 0);
        rst_n = 1'b0;
        #2;
        check("arst_valid", 128'(out_valid), 128'(0));
        check("arst_flags", 128'({flag_invalid, flag_nan, flag_inf, flag_sub, snan_cnt}), 128'(0));
        check("arst_ready", 128'(in_ready), 128'(1));
        exp_q.delete();
        m_valid = 0; m_inv = 0; m_nan = 0; m_inf = 0; m_sub = 0; m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, {32'h00000000, 32'h7FC00001}, 1, 0);

        // Drain.
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
